// File: rtl/tb_stim_ctrl.sv
// tb_stim_ctrl: testbench stimulus controller.
//
// Sequences a simulation through IDLE -> WARMUP -> RUN -> DRAIN -> DONE and, while in RUN,
// produces per-channel pseudo-random stall / valid-suppression patterns from 16-bit Galois
// LFSRs. The patterns are fully reproducible after every reset.
//
// Ports:
//   clk        in   clock; all state updates on its rising edge
//   reset_     in   synchronous active-low reset
//   stop_sim   in   level request to leave RUN (only looked at in RUN)
//   stall      out  [NCH] per-channel stall
//   valid_off  out  [NCH] per-channel valid suppression (never together with stall)
//   cmp_on     out  compare enable (WARMUP, RUN, DRAIN)
//   run_on     out  high in RUN
//   done       out  high in DONE
//   cyc_cnt    out  [32] saturating count of RUN cycles elapsed
module tb_stim_ctrl #(
  parameter int unsigned NCH       = 2,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int unsigned STALL_THR = 64,
  parameter int unsigned VOFF_THR  = 32,
  parameter int unsigned START_DLY = 4,
  parameter int unsigned DRAIN_CYC = 8,
  parameter int unsigned MAX_STALL = 3
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             stop_sim,
  output logic [NCH-1:0]   stall,
  output logic [NCH-1:0]   valid_off,
  output logic             cmp_on,
  output logic             run_on,
  output logic             done,
  output logic [31:0]      cyc_cnt
);

  localparam logic [8:0]  StallThr  = 9'(STALL_THR);
  localparam logic [8:0]  VoffThr   = 9'(VOFF_THR);
  localparam logic [7:0]  WarmLast  = 8'(START_DLY - 1);
  localparam logic [7:0]  DrainLast = 8'(DRAIN_CYC - 1);
  localparam logic [3:0]  MaxStall  = 4'(MAX_STALL);
  localparam logic [15:0] LfsrPoly  = 16'hB400;

  typedef enum logic [2:0] {
    StIdle,
    StWarmup,
    StRun,
    StDrain,
    StDone
  } state_e;

  // Per-channel seed; an all-zero LFSR would lock up, so it is replaced by 1.
  function automatic logic [15:0] seed_of(input int ch);
    logic [15:0] s;
    s = SEED ^ 16'(ch * 32'h1F35);
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

  // Right-shifting Galois step.
  function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
    logic [15:0] n;
    n = l >> 1;
    if (l[0]) n = n ^ LfsrPoly;
    return n;
  endfunction

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [31:0]     cyc_q, cyc_d;
  logic [15:0]     lfsr_q [NCH];
  logic [15:0]     lfsr_d [NCH];
  logic [3:0]      rl_q [NCH];
  logic [3:0]      rl_d [NCH];
  logic [NCH-1:0]  raw_stall, raw_voff;
  logic [NCH-1:0]  stall_q, stall_d;
  logic [NCH-1:0]  voff_q, voff_d;
  logic            cmp_q, cmp_d;
  logic            run_q, run_d;
  logic            done_q, done_d;

  // Next-state, phase counter and RUN cycle counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    case (state_q)
      StIdle: begin
        state_d = StWarmup;
        cnt_d   = '0;
      end
      StWarmup: begin
        if (cnt_q == WarmLast) begin
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StRun: begin
        if (cyc_q != 32'hFFFF_FFFF) cyc_d = cyc_q + 32'd1;
        if (stop_sim) begin
          state_d = StDrain;
          cnt_d   = '0;
        end
      end
      StDrain: begin
        if (cnt_q == DrainLast) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StDone:  state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // The LFSR value loaded for a RUN cycle is also the one its outputs are derived from, so
  // the first RUN cycle sees the seed and each further RUN cycle sees one more step.
  always_comb begin
    for (int i = 0; i < int'(NCH); i++) begin
      lfsr_d[i]    = (state_q == StRun) ? lfsr_adv(lfsr_q[i]) : lfsr_q[i];
      raw_stall[i] = ({1'b0, lfsr_d[i][7:0]} < StallThr);
      raw_voff[i]  = ({1'b0, lfsr_d[i][15:8]} < VoffThr);
    end
  end

  // Stall run-length limit and stall/valid_off exclusivity.
  always_comb begin
    for (int i = 0; i < int'(NCH); i++) begin
      stall_d[i] = 1'b0;
      voff_d[i]  = 1'b0;
      rl_d[i]    = '0;
      if (state_d == StRun) begin
        if (raw_stall[i] && (rl_q[i] < MaxStall)) begin
          stall_d[i] = 1'b1;
          rl_d[i]    = rl_q[i] + 4'd1;
        end
        voff_d[i] = raw_voff[i] & ~stall_d[i];
      end
    end
  end

  always_comb begin
    cmp_d  = (state_d == StWarmup) || (state_d == StRun) || (state_d == StDrain);
    run_d  = (state_d == StRun);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      cyc_q   <= '0;
      stall_q <= '0;
      voff_q  <= '0;
      cmp_q   <= 1'b0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < int'(NCH); i++) begin
        lfsr_q[i] <= seed_of(i);
        rl_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      stall_q <= stall_d;
      voff_q  <= voff_d;
      cmp_q   <= cmp_d;
      run_q   <= run_d;
      done_q  <= done_d;
      for (int i = 0; i < int'(NCH); i++) begin
        lfsr_q[i] <= lfsr_d[i];
        rl_q[i]   <= rl_d[i];
      end
    end
  end

  assign stall     = stall_q;
  assign valid_off = voff_q;
  assign cmp_on    = cmp_q;
  assign run_on    = run_q;
  assign done      = done_q;
  assign cyc_cnt   = cyc_q;

endmodule
